// File: rtl/ds2_c64_pkg.sv
// ds2_c64_pkg: shared constants and types for the DualShock 2 to C64 joystick bridge.
//   Key bit indices, joy_n bit positions, stick centre/idle codes and the
//   packed controller-state payload carried through the resynchroniser.
package ds2_c64_pkg;

   localparam int unsigned KEY_W   = 16;
   localparam int unsigned STICK_W = 8;
   localparam int unsigned JOY_W   = 5;

   // keys_in bit order
   localparam int unsigned KEY_SELECT   = 0;
   localparam int unsigned KEY_RSTICK   = 1;
   localparam int unsigned KEY_LSTICK   = 2;
   localparam int unsigned KEY_START    = 3;
   localparam int unsigned KEY_UP       = 4;
   localparam int unsigned KEY_RIGHT    = 5;
   localparam int unsigned KEY_DOWN     = 6;
   localparam int unsigned KEY_LEFT     = 7;
   localparam int unsigned KEY_L2       = 8;
   localparam int unsigned KEY_R2       = 9;
   localparam int unsigned KEY_L1       = 10;
   localparam int unsigned KEY_R1       = 11;
   localparam int unsigned KEY_TRIANGLE = 12;
   localparam int unsigned KEY_CIRCLE   = 13;
   localparam int unsigned KEY_CROSS    = 14;
   localparam int unsigned KEY_SQUARE   = 15;

   // joy_n bit positions (active-low on the port)
   localparam int unsigned JOY_UP    = 0;
   localparam int unsigned JOY_DOWN  = 1;
   localparam int unsigned JOY_LEFT  = 2;
   localparam int unsigned JOY_RIGHT = 3;
   localparam int unsigned JOY_FIRE  = 4;

   localparam logic [STICK_W-1:0] STICK_CENTRE = 8'd128;
   localparam logic [STICK_W-1:0] STICK_IDLE   = 8'h00;

   // Complete controller snapshot (48 bits)
   typedef struct packed {
      logic [KEY_W-1:0]   keys;
      logic [STICK_W-1:0] lx;
      logic [STICK_W-1:0] ly;
      logic [STICK_W-1:0] rx;
      logic [STICK_W-1:0] ry;
   } ds2_state_t;

   // Released keys, centred sticks
   localparam ds2_state_t DS2_REST = '{
      keys: '0,
      lx:   STICK_CENTRE,
      ly:   STICK_CENTRE,
      rx:   STICK_CENTRE,
      ry:   STICK_CENTRE
   };

   // All four sticks at the idle code means no controller is answering
   function automatic logic sticks_idle(input ds2_state_t s);
      return (s.lx == STICK_IDLE) && (s.ly == STICK_IDLE) &&
             (s.rx == STICK_IDLE) && (s.ry == STICK_IDLE);
   endfunction

endpackage

// File: rtl/ds2_c64_joy_if.sv
// ds2_c64_joy_if: controller-state inputs and C64 control-port outputs.
//   keys_in, stick_lx/ly/rx/ry : decoded controller state (controller side drives)
//   joy_n, fire2_n, pot_x/pot_y, ctrl_present : control-port signals (bridge drives)
//   modport master : controller side / consumer of port signals
//   modport slave  : the bridge
interface ds2_c64_joy_if;
   import ds2_c64_pkg::*;

   logic [KEY_W-1:0]   keys_in;
   logic [STICK_W-1:0] stick_lx;
   logic [STICK_W-1:0] stick_ly;
   logic [STICK_W-1:0] stick_rx;
   logic [STICK_W-1:0] stick_ry;

   logic [JOY_W-1:0]   joy_n;
   logic               fire2_n;
   logic [STICK_W-1:0] pot_x;
   logic [STICK_W-1:0] pot_y;
   logic               ctrl_present;

   modport master (
      output keys_in, stick_lx, stick_ly, stick_rx, stick_ry,
      input  joy_n, fire2_n, pot_x, pot_y, ctrl_present
   );

   modport slave (
      input  keys_in, stick_lx, stick_ly, stick_rx, stick_ry,
      output joy_n, fire2_n, pot_x, pot_y, ctrl_present
   );

endinterface

// File: rtl/ds2_axis_hyst.sv
// ds2_axis_hyst: one analog axis to neg/pos digital directions with hysteresis.
//   clk, rst        : system clock, synchronous active-high reset
//   value           : axis position, 0x00 = neg end, 0xFF = pos end
//   enable          : 0 forces both directions (and their held state) clear
//   th_on, th_off   : deflection from centre to assert / below which to release
//   neg_c, pos_c    : current direction decisions (combinational from value)
module ds2_axis_hyst
   import ds2_c64_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [STICK_W-1:0] value,
   input  logic               enable,
   input  logic [STICK_W-1:0] th_on,
   input  logic [STICK_W-1:0] th_off,
   output logic               neg_c,
   output logic               pos_c
);

   localparam int unsigned CW = STICK_W + 1;

   logic          neg_q;
   logic          pos_q;
   logic [CW-1:0] v9;
   logic [CW-1:0] centre9;
   logic [CW-1:0] neg_on_lim;
   logic [CW-1:0] neg_off_lim;
   logic [CW-1:0] pos_on_lim;
   logic [CW-1:0] pos_off_lim;

   // Limits in 9 bits so centre +/- threshold never wraps
   always_comb begin
      v9          = {1'b0, value};
      centre9     = {1'b0, STICK_CENTRE};
      neg_on_lim  = centre9 - {1'b0, th_on};
      neg_off_lim = centre9 - {1'b0, th_off};
      pos_on_lim  = centre9 + {1'b0, th_on};
      pos_off_lim = centre9 + {1'b0, th_off};
   end

   // Assert beyond the on-limit; once asserted, hold until inside the off-limit
   always_comb begin
      neg_c = enable & ((v9 <= neg_on_lim) | (neg_q & (v9 <= neg_off_lim)));
      pos_c = enable & ((v9 >= pos_on_lim) | (pos_q & (v9 >= pos_off_lim)));
   end

   // Held direction state
   always_ff @(posedge clk) begin
      if (rst) begin
         neg_q <= 1'b0;
         pos_q <= 1'b0;
      end else begin
         neg_q <= neg_c;
         pos_q <= pos_c;
      end
   end

endmodule

// File: rtl/ds2_c64_joy.sv
// ds2_c64_joy: DualShock 2 controller state to C64 control-port signals.
//   clk, rst       : system clock, synchronous active-high reset
//   vsync          : frame sync, asynchronous, rising edge paces autofire and paddles
//   cfg_use_stick  : map left stick onto directions
//   cfg_autofire   : autofire on square (only with DS2_AUTOFIRE_EN)
//   bus (slave)    : keys_in/stick_* in; joy_n, fire2_n, pot_x, pot_y, ctrl_present out
// Build option: define DS2_AUTOFIRE_EN to include the vsync-paced autofire on square;
// otherwise square is a plain fire button and cfg_autofire/AF_PERIOD are ignored.
module ds2_c64_joy
   import ds2_c64_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 1024,  // >= 2
   parameter int unsigned TH_ON         = 64,
   parameter int unsigned TH_OFF        = 40,
   parameter int unsigned AF_PERIOD     = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            vsync,
   input  logic            cfg_use_stick,
   input  logic            cfg_autofire,
   ds2_c64_joy_if.slave    bus
);

   localparam int unsigned CNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STABLE_CYCLES - 2);

   ds2_state_t         raw;
   ds2_state_t         sync1;
   ds2_state_t         sync2;
   ds2_state_t         last;
   ds2_state_t         stable;
   logic [CNT_W-1:0]   cnt;

   logic               vs_meta;
   logic               vs_sync;
   logic               vs_prev;
   logic               vs_rise;

   logic               present_c;
   logic [KEY_W-1:0]   keys_eff;
   logic [STICK_W-1:0] lx_eff;
   logic [STICK_W-1:0] ly_eff;
   logic [STICK_W-1:0] rx_eff;
   logic [STICK_W-1:0] ry_eff;

   logic               x_neg;
   logic               x_pos;
   logic               y_neg;
   logic               y_pos;
   logic               fire_c;
   logic [JOY_W-1:0]   joy_c;
   logic               unused_keys;

   assign raw = '{
      keys: bus.keys_in,
      lx:   bus.stick_lx,
      ly:   bus.stick_ly,
      rx:   bus.stick_rx,
      ry:   bus.stick_ry
   };

   // Two-flop resynchronisers; resetting to the rest pattern avoids a spurious filter restart
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1   <= DS2_REST;
         sync2   <= DS2_REST;
         vs_meta <= 1'b0;
         vs_sync <= 1'b0;
         vs_prev <= 1'b0;
      end else begin
         sync1   <= raw;
         sync2   <= sync1;
         vs_meta <= vsync;
         vs_sync <= vs_meta;
         vs_prev <= vs_sync;
      end
   end

   assign vs_rise = vs_sync & ~vs_prev;

   // Stability filter: any changed bit restarts the window; stable loads on the
   // edge where cnt reaches STABLE_CYCLES-1, keeping total latency at STABLE_CYCLES+3
   always_ff @(posedge clk) begin
      if (rst) begin
         last   <= DS2_REST;
         stable <= DS2_REST;
         cnt    <= '0;
      end else if (sync2 != last) begin
         last <= sync2;
         cnt  <= '0;
      end else begin
         if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
         end
         if (cnt >= CNT_LOAD) begin
            stable <= last;
         end
      end
   end

   // Idle bus: sticks read as centred and keys as released
   always_comb begin
      present_c = ~sticks_idle(stable);
      keys_eff  = present_c ? stable.keys : '0;
      lx_eff    = present_c ? stable.lx : STICK_CENTRE;
      ly_eff    = present_c ? stable.ly : STICK_CENTRE;
      rx_eff    = present_c ? stable.rx : STICK_CENTRE;
      ry_eff    = present_c ? stable.ry : STICK_CENTRE;
   end

   ds2_axis_hyst u_hyst_x (
      .clk    (clk),
      .rst    (rst),
      .value  (lx_eff),
      .enable (cfg_use_stick),
      .th_on  (STICK_W'(TH_ON)),
      .th_off (STICK_W'(TH_OFF)),
      .neg_c  (x_neg),
      .pos_c  (x_pos)
   );

   ds2_axis_hyst u_hyst_y (
      .clk    (clk),
      .rst    (rst),
      .value  (ly_eff),
      .enable (cfg_use_stick),
      .th_on  (STICK_W'(TH_ON)),
      .th_off (STICK_W'(TH_OFF)),
      .neg_c  (y_neg),
      .pos_c  (y_pos)
   );

`ifdef DS2_AUTOFIRE_EN
   logic [7:0] af_cnt;
   logic       af_phase;
   logic       sq_prev;

   // Autofire phase: held in its asserted start state unless square has been held
   // for more than one cycle with autofire on, so a press beats a coincident vsync edge
   always_ff @(posedge clk) begin
      if (rst) begin
         af_cnt   <= '0;
         af_phase <= 1'b1;
         sq_prev  <= 1'b0;
      end else begin
         sq_prev <= keys_eff[KEY_SQUARE];
         if (!keys_eff[KEY_SQUARE] || !sq_prev || !cfg_autofire) begin
            af_cnt   <= '0;
            af_phase <= 1'b1;
         end else if (vs_rise) begin
            if (af_cnt == 8'(AF_PERIOD - 1)) begin
               af_cnt   <= '0;
               af_phase <= ~af_phase;
            end else begin
               af_cnt <= af_cnt + 8'd1;
            end
         end
      end
   end

   assign fire_c = keys_eff[KEY_CROSS] | (keys_eff[KEY_SQUARE] & af_phase);
`else
   logic unused_af;

   assign unused_af = cfg_autofire | (AF_PERIOD == 0);
   assign fire_c    = keys_eff[KEY_CROSS] | keys_eff[KEY_SQUARE];
`endif

   // Key OR stick per direction; opposing pairs cancel
   always_comb begin
      logic up;
      logic down;
      logic left;
      logic right;
      joy_c = '0;
      up    = keys_eff[KEY_UP]    | y_neg;
      down  = keys_eff[KEY_DOWN]  | y_pos;
      left  = keys_eff[KEY_LEFT]  | x_neg;
      right = keys_eff[KEY_RIGHT] | x_pos;
      joy_c[JOY_UP]    = up    & ~down;
      joy_c[JOY_DOWN]  = down  & ~up;
      joy_c[JOY_LEFT]  = left  & ~right;
      joy_c[JOY_RIGHT] = right & ~left;
      joy_c[JOY_FIRE]  = fire_c;
   end

   assign unused_keys = ^{keys_eff[KEY_SELECT], keys_eff[KEY_RSTICK], keys_eff[KEY_LSTICK],
                          keys_eff[KEY_START], keys_eff[KEY_L2], keys_eff[KEY_R2],
                          keys_eff[KEY_L1], keys_eff[KEY_R1], keys_eff[KEY_TRIANGLE]};

   // Output registers; paddles refresh only on a vsync edge
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.joy_n        <= '1;
         bus.fire2_n      <= 1'b1;
         bus.pot_x        <= STICK_CENTRE;
         bus.pot_y        <= STICK_CENTRE;
         bus.ctrl_present <= 1'b0;
      end else begin
         bus.joy_n        <= ~joy_c;
         bus.fire2_n      <= ~keys_eff[KEY_CIRCLE];
         bus.ctrl_present <= present_c;
         if (vs_rise) begin
            bus.pot_x <= rx_eff;
            bus.pot_y <= ry_eff;
         end
      end
   end

endmodule

// File: tb/tb_ds2_c64_joy.sv
`timescale 1ns/1ps
// tb_ds2_c64_joy: directed bench for ds2_c64_joy with a scoreboard queue of
// expected port values, drained and compared at each observation point.
module tb_ds2_c64_joy;
   import ds2_c64_pkg::*;

   localparam int unsigned STABLE = 1024;
   localparam int unsigned AFP    = 4;
   localparam int unsigned SETTLE = STABLE + 40;

   localparam int S_JOY   = 0;
   localparam int S_FIRE2 = 1;
   localparam int S_POTX  = 2;
   localparam int S_POTY  = 3;
   localparam int S_PRES  = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic vsync = 1'b0;
   logic cfg_use_stick = 1'b1;
   logic cfg_autofire = 1'b1;

   ds2_c64_joy_if bus ();

   ds2_c64_joy #(
      .STABLE_CYCLES (STABLE),
      .TH_ON         (64),
      .TH_OFF        (40),
      .AF_PERIOD     (AFP)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .vsync         (vsync),
      .cfg_use_stick (cfg_use_stick),
      .cfg_autofire  (cfg_autofire),
      .bus           (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      tag;
      int         sel;
      logic [7:0] val;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   function automatic logic [7:0] observe(input int sel);
      case (sel)
         S_JOY:   return {3'b000, bus.joy_n};
         S_FIRE2: return {7'b0, bus.fire2_n};
         S_POTX:  return bus.pot_x;
         S_POTY:  return bus.pot_y;
         S_PRES:  return {7'b0, bus.ctrl_present};
         default: return 8'hxx;
      endcase
   endfunction

   function automatic logic [15:0] key(input int unsigned idx);
      return 16'(1) << idx;
   endfunction

   task automatic push_exp(input string tag, input int sel, input logic [7:0] val);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.val = val;
      sb.push_back(e);
   endtask

   task automatic drain();
      while (sb.size() > 0) begin
         exp_t       e;
         logic [7:0] o;
         e = sb.pop_front();
         o = observe(e.sel);
         total++;
         assert (o === e.val)
         else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", e.tag, o, e.val);
         end
      end
   endtask

   // Advance n rising edges and land 1 ns after the last one
   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic vs_pulse();
      vsync = 1'b1;
      cycles(8);
      vsync = 1'b0;
      cycles(8);
   endtask

   task automatic set_sticks(input logic [7:0] lx, input logic [7:0] ly,
                             input logic [7:0] rx, input logic [7:0] ry);
      bus.stick_lx = lx;
      bus.stick_ly = ly;
      bus.stick_rx = rx;
      bus.stick_ry = ry;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.keys_in = '0;
      set_sticks(8'h80, 8'h80, 8'h80, 8'h80);

      // Reset values
      cycles(3);
      push_exp("rst_joy", S_JOY, 8'h1F);
      push_exp("rst_fire2", S_FIRE2, 8'h01);
      push_exp("rst_potx", S_POTX, 8'h80);
      push_exp("rst_poty", S_POTY, 8'h80);
      push_exp("rst_present", S_PRES, 8'h00);
      drain();

      // Reset release
      rst = 1'b0;
      cycles(STABLE + 3);
      push_exp("rel_present", S_PRES, 8'h01);
      push_exp("rel_joy", S_JOY, 8'h1F);
      push_exp("rel_potx", S_POTX, 8'h80);
      drain();

      // Filter restart: a glitch inside the window restarts it; exact latency on final set
      bus.keys_in = key(KEY_CROSS);
      cycles(500);
      bus.keys_in = '0;
      cycles(10);
      bus.keys_in = key(KEY_CROSS);
      cycles(STABLE + 2);
      push_exp("lat_before", S_JOY, 8'h1F);
      drain();
      cycles(1);
      push_exp("lat_exact", S_JOY, 8'h0F);
      drain();
      bus.keys_in = '0;
      cycles(SETTLE);
      push_exp("cross_release", S_JOY, 8'h1F);
      drain();

      // Hysteresis on X
      bus.stick_lx = 8'h41;
      cycles(SETTLE);
      push_exp("hyst_41_off", S_JOY, 8'h1F);
      drain();
      bus.stick_lx = 8'h40;
      cycles(SETTLE);
      push_exp("hyst_40_on", S_JOY, 8'h1B);
      drain();
      bus.stick_lx = 8'h55;
      cycles(SETTLE);
      push_exp("hyst_55_hold", S_JOY, 8'h1B);
      drain();
      bus.stick_lx = 8'h59;
      cycles(SETTLE);
      push_exp("hyst_59_rel", S_JOY, 8'h1F);
      drain();
      bus.stick_lx = 8'hC0;
      cycles(SETTLE);
      push_exp("hyst_c0_right", S_JOY, 8'h17);
      drain();

      // Stick mapping disable
      bus.stick_lx = 8'h00;
      cfg_use_stick = 1'b0;
      cycles(SETTLE);
      push_exp("stick_disabled", S_JOY, 8'h1F);
      drain();
      cfg_use_stick = 1'b1;
      cycles(4);
      push_exp("stick_reenabled", S_JOY, 8'h1B);
      drain();
      bus.stick_lx = 8'h80;
      cycles(SETTLE);

      // Conflict resolution
      bus.keys_in = key(KEY_UP);
      cycles(SETTLE);
      push_exp("up_only", S_JOY, 8'h1E);
      drain();
      bus.keys_in = key(KEY_UP) | key(KEY_DOWN);
      cycles(SETTLE);
      push_exp("up_down", S_JOY, 8'h1F);
      drain();
      bus.keys_in = key(KEY_LEFT) | key(KEY_RIGHT) | key(KEY_DOWN);
      cycles(SETTLE);
      push_exp("lr_cancel_down", S_JOY, 8'h1D);
      drain();

      // Second button
      bus.keys_in = key(KEY_CIRCLE);
      cycles(SETTLE);
      push_exp("circle", S_FIRE2, 8'h00);
      push_exp("circle_joy", S_JOY, 8'h1F);
      drain();
      bus.keys_in = '0;

      // Paddles update only on vsync
      set_sticks(8'h80, 8'h80, 8'h12, 8'hEF);
      cycles(SETTLE);
      push_exp("pot_hold_x", S_POTX, 8'h80);
      push_exp("pot_hold_y", S_POTY, 8'h80);
      drain();
      vs_pulse();
      push_exp("pot_upd_x", S_POTX, 8'h12);
      push_exp("pot_upd_y", S_POTY, 8'hEF);
      drain();

      // Autofire over 12 frames, sampled before each vsync pulse
      bus.keys_in = key(KEY_SQUARE);
      cycles(SETTLE);
      for (int k = 1; k <= 12; k++) begin
         logic [7:0] ef;
`ifdef DS2_AUTOFIRE_EN
         ef = ((((k - 1) / AFP) % 2) == 0) ? 8'h0F : 8'h1F;
`else
         ef = 8'h0F;
`endif
         push_exp($sformatf("autofire_f%0d", k), S_JOY, ef);
         drain();
         vs_pulse();
      end
      bus.keys_in = '0;
      cycles(SETTLE);

      // Idle bus masks everything
      bus.keys_in = key(KEY_UP) | key(KEY_CROSS) | key(KEY_CIRCLE);
      set_sticks(8'h00, 8'h00, 8'h00, 8'h00);
      cycles(SETTLE);
      push_exp("idle_present", S_PRES, 8'h00);
      push_exp("idle_joy", S_JOY, 8'h1F);
      push_exp("idle_fire2", S_FIRE2, 8'h01);
      drain();
      vs_pulse();
      push_exp("idle_potx", S_POTX, 8'h80);
      push_exp("idle_poty", S_POTY, 8'h80);
      drain();

      // Reset in mid-operation
      bus.keys_in = key(KEY_CROSS) | key(KEY_CIRCLE);
      set_sticks(8'h80, 8'h80, 8'h33, 8'h80);
      cycles(SETTLE);
      vs_pulse();
      push_exp("pre_rst_joy", S_JOY, 8'h0F);
      push_exp("pre_rst_potx", S_POTX, 8'h33);
      push_exp("pre_rst_present", S_PRES, 8'h01);
      drain();
      rst = 1'b1;
      cycles(1);
      push_exp("mid_rst_joy", S_JOY, 8'h1F);
      push_exp("mid_rst_fire2", S_FIRE2, 8'h01);
      push_exp("mid_rst_potx", S_POTX, 8'h80);
      push_exp("mid_rst_present", S_PRES, 8'h00);
      drain();
      rst = 1'b0;
      cycles(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ds2_c64_joy.md
# ds2_c64_joy

Maps the decoded DualShock 2 controller state (16 keys plus 4 analog sticks, produced in the slow SPI clock domain) onto C64 control-port signals in the system `clk` domain. The block performs the following steps:
- resynchronises the controller bus and rejects torn mid-transfer values;
- converts the left stick to digital directions with hysteresis;
- resolves conflicting directions;
- generates autofire paced by `vsync`.

It sits directly downstream of the controller interface and drives the CIA joystick inputs and the SID POT lines.

## Interface
- `STABLE_CYCLES`, 1024: number of consecutive equal samples required before the input vector is accepted.
- `TH_ON`, 64: stick deflection from centre at which a direction asserts. Constraint: `TH_OFF` < `TH_ON` ≤ 127.
- `TH_OFF`, 40: deflection below which an asserted direction releases.
- `AF_PERIOD`, 4: autofire half-period, counted in `vsync` rising edges. Range 1–255.

- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high; clock `clk`.
- `vsync` in 1: frame sync, active-high, asynchronous to `clk`.
- `keys_in` in 16: active-high keys. Bit order: 0 select, 1 rstick, 2 lstick, 3 start, 4 up, 5 right, 6 down, 7 left, 8 l2, 9 r2, 10 l1, 11 r1, 12 triangle, 13 circle, 14 cross, 15 square.
- `stick_lx`, `stick_ly`, `stick_rx`, `stick_ry` in 8 each: 0x00 = left/up, 0xFF = right/down.
- `cfg_use_stick` in 1: enables left-stick-to-direction mapping.
- `cfg_autofire` in 1: enables autofire on square.
- `joy_n` out 5: active-low {fire, right, left, down, up} (bits 4..0).
- `fire2_n` out 1: active-low second button (circle).
- `pot_x`, `pot_y` out 8: paddle values.
- `ctrl_present` out 1: controller detected.

## Operation
- **Resynchronisation.** All 48 input bits (keys plus sticks) pass through a 2-flop synchroniser. `vsync` also passes through a 2-flop synchroniser and a rising-edge detector.
- **Stability filter.**
  - When the synchronised vector differs from the last sample: `last` ← sample and `cnt` ← 0.
  - Otherwise `cnt` increments, saturating at `STABLE_CYCLES-1`.
  - When `cnt` = `STABLE_CYCLES-1` and the vector is still equal: `stable` ← `last`.
- **Presence detection.** `ctrl_present` = 0 when all four stable sticks are 0x00 (the bus idle pattern), otherwise 1. While not present:
  - the sticks are treated as 0x80;
  - all keys are treated as released.
- **Axis hysteresis** (X and Y independently, centre C = 128):
  - neg asserts when v ≤ C−`TH_ON`, releases when v > C−`TH_OFF`;
  - pos asserts when v ≥ C+`TH_ON`, releases when v < C+`TH_OFF`;
  - compare in 9-bit arithmetic, so there is no wrap;
  - stick directions are cleared while `cfg_use_stick` = 0.
- **Direction combining.** dir = key OR stick. If up and down are both set, both are released; left and right are handled the same way.
- **Autofire.**
  - While square is held and `cfg_autofire` = 1, the autofire phase starts asserted and toggles every `AF_PERIOD` `vsync` edges.
  - The counter and phase reset whenever square is released.
  - fire = cross OR (square AND phase).
- **Second button.** `fire2_n` = ~circle.
- **Paddles.** `pot_x`/`pot_y` take the stable `stick_rx`/`stick_ry` values on each `vsync` rising edge only, never mid-frame.

## Timing
- Reset values:
  - `joy_n` = 5'b11111, `fire2_n` = 1, `pot_x` = `pot_y` = 0x80, `ctrl_present` = 0;
  - stable vector = keys 0, sticks 0x80;
  - `cnt` = 0, autofire phase = 1, autofire counter = 0.
- Latency from an input change that is then held: `joy_n` changes exactly `STABLE_CYCLES`+3 `clk` cycles later (2 synchroniser cycles, the filter, 1 output register).
- A change on any bit during the filter window restarts the window.
- Pot values update 1 cycle after the detected `vsync` edge, i.e. 3–4 cycles after the raw `vsync` rise.
- If a `vsync` edge and a square press occur in the same cycle, the press wins: the counter resets and the phase is asserted.
- `rst` asserted mid-operation returns every output to its reset value on the next edge.

## Configuration
- `DS2_AUTOFIRE_EN` defined: autofire logic as described above.
- `DS2_AUTOFIRE_EN` undefined:
  - fire = cross OR square;
  - `cfg_autofire` and `AF_PERIOD` are ignored;
  - no autofire registers are synthesised.

## Structure
- Package `ds2_c64_pkg`:
  - key bit-index constants;
  - `joy_n` bit positions;
  - `STICK_CENTRE` = 8'd128;
  - `STICK_IDLE` = 8'h00.
- Sub-module `ds2_axis_hyst`: one axis, inputs value, enable, and thresholds; outputs neg and pos. Instantiated twice (X, Y).

## Test plan
- **Reset release:** release reset with sticks at 0x80 and keys at 0 → `joy_n` = 11111, pots = 0x80, and after `STABLE_CYCLES`+3 cycles `ctrl_present` = 1.
- **Filter restart:** set keys bit 14 (cross), toggle it off after 500 cycles, then set it again and hold → `joy_n[4]` goes to 0 exactly 1027 cycles after the final set.
- **Hysteresis:** with `cfg_use_stick` = 1, step `stick_lx` through 0x40 → left asserts; then 0x55 → left remains asserted; then 0x59 → left releases.
- **Conflict resolution:** set up and down keys together → `joy_n[1:0]` = 11.
- **Autofire:** with `cfg_autofire` = 1, hold square across 12 `vsync` pulses → fire pattern is 0 for 4 frames, 1 for 4 frames, 0 for 4 frames.
- **Idle bus:** drive all sticks to 0x00 → `ctrl_present` = 0 and `joy_n` = 11111 despite the corner stick values.
